// File: rtl/io_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_port_ctrl
// Brief    : Four-phase req/ack I/O port controller serving NCH device channels.
//            Optional handshake timeout enabled by macro IO_PORT_CTRL_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module io_port_ctrl #(
    parameter int  WIDTH     = 16,
    parameter int  NCH       = 4,
    parameter int  TO_CYCLES = 1023,
    localparam int CHW       = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 cmd_start,
    input  logic                 cmd_dir,
    input  logic [CHW-1:0]       cmd_ch,
    input  logic [WIDTH-1:0]     cmd_wdata,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     rdata,
    output logic                 err_timeout,
    output logic                 err_badch,
    output logic [NCH-1:0]       inp_req,
    input  logic [NCH-1:0]       inp_ack,
    input  logic [NCH*WIDTH-1:0] inp_data,
    output logic [NCH-1:0]       out_req,
    input  logic [NCH-1:0]       out_ack,
    output logic [WIDTH-1:0]     out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CHW-1:0]   r_ch;
    logic             r_dir;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_rdata;
    logic             r_done;
    logic             r_err_badch;

    logic             w_accept;
    logic             w_badch;
    logic             w_ack_sel;
    logic             w_timeout;
    logic             w_done_nxt;
    logic             w_load_rdata;
    logic [WIDTH-1:0] w_inp_sel;

    assign w_accept = (r_state == IDLE) && cmd_start;
    assign w_badch  = 32'(cmd_ch) >= 32'(NCH);

    // Channel decode by comparison so out-of-range indices never address a bit.
    always_comb begin
        w_ack_sel = 1'b0;
        w_inp_sel = '0;
        inp_req   = '0;
        out_req   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_ch == CHW'(k)) begin
                w_ack_sel  = r_dir ? out_ack[k] : inp_ack[k];
                w_inp_sel  = inp_data[k*WIDTH +: WIDTH];
                inp_req[k] = (r_state == REQ) && !r_dir;
                out_req[k] = (r_state == REQ) && r_dir;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_done_nxt   = 1'b0;
        w_load_rdata = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_badch) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (w_timeout) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_ack_sel) begin
                    w_state_nxt  = DROP;
                    w_load_rdata = !r_dir;
                end
            end
            DROP: begin
                if (!w_ack_sel || w_timeout) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state     <= IDLE;
            r_ch        <= '0;
            r_dir       <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_err_badch <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_ch        <= cmd_ch;
                r_dir       <= cmd_dir;
                r_wdata     <= cmd_wdata;
                r_err_badch <= w_badch;
            end
            if (w_load_rdata) begin
                r_rdata <= w_inp_sel;
            end
        end
    end

`ifdef IO_PORT_CTRL_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TO_CYCLES + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err_timeout;

    // A DROP cycle that sees ack low completes normally even on the last count.
    assign w_timeout = (r_cnt == c_CNT_W'(TO_CYCLES - 1)) &&
                       ((r_state == REQ) || ((r_state == DROP) && w_ack_sel));

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_cnt         <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_accept) begin
                r_err_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign err_badch = r_err_badch;
    assign out_data  = (busy && r_dir) ? r_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_io_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_port_ctrl
// Brief    : Self-checking bench for io_port_ctrl with randomized transfers.
// Revision : 1.0
// ============================================================================
module tb_io_port_ctrl;

    localparam int WIDTH     = 16;
    localparam int NCH       = 4;
    localparam int TO_CYCLES = 8;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cmd_start, cmd_dir;
    logic [1:0]  cmd_ch;
    logic [15:0] cmd_wdata;
    logic        busy, done, err_timeout, err_badch;
    logic [15:0] rdata, out_data;
    logic [3:0]  inp_req, inp_ack, out_req, out_ack;
    logic [63:0] inp_data;

    logic        b_cmd_start, b_cmd_dir;
    logic [1:0]  b_cmd_ch;
    logic [15:0] b_cmd_wdata;
    logic        b_busy, b_done, b_err_timeout, b_err_badch;
    logic [15:0] b_rdata, b_out_data;
    logic [2:0]  b_inp_req, b_inp_ack, b_out_req, b_out_ack;
    logic [47:0] b_inp_data;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        sel_dir;
    logic [1:0]  sel_ch;
    logic        sel_ack;
    logic [15:0] sel_data;
    logic [15:0] m_rdata;

    always #5 clk = ~clk;

    io_port_ctrl #(.WIDTH(WIDTH), .NCH(NCH), .TO_CYCLES(TO_CYCLES)) u_dut (
        .clk(clk), .rst_b(rst_b), .cmd_start(cmd_start), .cmd_dir(cmd_dir),
        .cmd_ch(cmd_ch), .cmd_wdata(cmd_wdata), .busy(busy), .done(done),
        .rdata(rdata), .err_timeout(err_timeout), .err_badch(err_badch),
        .inp_req(inp_req), .inp_ack(inp_ack), .inp_data(inp_data),
        .out_req(out_req), .out_ack(out_ack), .out_data(out_data)
    );

    io_port_ctrl #(.WIDTH(WIDTH), .NCH(3), .TO_CYCLES(TO_CYCLES)) u_dut3 (
        .clk(clk), .rst_b(rst_b), .cmd_start(b_cmd_start), .cmd_dir(b_cmd_dir),
        .cmd_ch(b_cmd_ch), .cmd_wdata(b_cmd_wdata), .busy(b_busy), .done(b_done),
        .rdata(b_rdata), .err_timeout(b_err_timeout), .err_badch(b_err_badch),
        .inp_req(b_inp_req), .inp_ack(b_inp_ack), .inp_data(b_inp_data),
        .out_req(b_out_req), .out_ack(b_out_ack), .out_data(b_out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random traffic on every ack except the one the current command selects.
    task automatic noise();
        inp_ack  = 4'($urandom);
        out_ack  = 4'($urandom);
        inp_data = {$urandom, $urandom};
        if (sel_dir) out_ack[sel_ch] = sel_ack;
        else         inp_ack[sel_ch] = sel_ack;
        inp_data[sel_ch*WIDTH +: WIDTH] = sel_data;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},    32'(busy),     32'd0);
        chk({tag, "_done"},    32'(done),     32'd0);
        chk({tag, "_inp_req"}, 32'(inp_req),  32'd0);
        chk({tag, "_out_req"}, 32'(out_req),  32'd0);
        chk({tag, "_out_data"},32'(out_data), 32'd0);
        chk({tag, "_rdata"},   32'(rdata),    32'(m_rdata));
    endtask

    // Issues a command now; selected ack rises after d1 request cycles and is
    // held for d2 cycles. Returns in the cycle where done must be high.
    task automatic do_xfer(input logic dir, input logic [1:0] ch, input logic [15:0] wd,
                           input logic [15:0] dat, input int d1, input int d2,
                           input logic stray);
        logic [3:0]  exp_req;
        logic [15:0] exp_out;
        exp_req   = 4'b0001 << ch;
        exp_out   = dir ? wd : 16'h0;
        cmd_start = 1'b1;
        cmd_dir   = dir;
        cmd_ch    = ch;
        cmd_wdata = wd;
        sel_dir   = dir;
        sel_ch    = ch;
        sel_ack   = 1'b0;
        sel_data  = dat;
        tick();
        for (int i = 0; i <= d1; i++) begin
            chk("req_busy",     32'(busy),     32'd1);
            chk("req_done",     32'(done),     32'd0);
            chk("req_inp_req",  32'(inp_req),  32'(dir ? 4'b0 : exp_req));
            chk("req_out_req",  32'(out_req),  32'(dir ? exp_req : 4'b0));
            chk("req_out_data", 32'(out_data), 32'(exp_out));
            cmd_start = stray && (i == 0);
            cmd_dir   = ~dir;
            cmd_ch    = ch + 2'd1;
            cmd_wdata = 16'($urandom);
            if (i == d1) sel_ack = 1'b1;
            noise();
            tick();
        end
        if (!dir) m_rdata = dat;
        for (int i = 0; i < d2; i++) begin
            chk("drop_busy",     32'(busy),     32'd1);
            chk("drop_done",     32'(done),     32'd0);
            chk("drop_inp_req",  32'(inp_req),  32'd0);
            chk("drop_out_req",  32'(out_req),  32'd0);
            chk("drop_out_data", 32'(out_data), 32'(exp_out));
            chk("drop_rdata",    32'(rdata),    32'(m_rdata));
            cmd_start = stray && (i == 0);
            if (i == d2 - 1) sel_ack = 1'b0;
            noise();
            tick();
        end
        cmd_start = 1'b0;
        chk("fin_done",     32'(done),        32'd1);
        chk("fin_busy",     32'(busy),        32'd0);
        chk("fin_rdata",    32'(rdata),       32'(m_rdata));
        chk("fin_out_data", 32'(out_data),    32'd0);
        chk("fin_inp_req",  32'(inp_req),     32'd0);
        chk("fin_out_req",  32'(out_req),     32'd0);
        chk("fin_err_to",   32'(err_timeout), 32'd0);
        chk("fin_err_bad",  32'(err_badch),   32'd0);
    endtask

    initial begin
        int n;
        rst_b       = 1'b1;
        cmd_start   = 1'b0;
        cmd_dir     = 1'b0;
        cmd_ch      = 2'd0;
        cmd_wdata   = 16'h0;
        inp_ack     = 4'h0;
        out_ack     = 4'h0;
        inp_data    = 64'h0;
        b_cmd_start = 1'b0;
        b_cmd_dir   = 1'b0;
        b_cmd_ch    = 2'd0;
        b_cmd_wdata = 16'h0;
        b_inp_ack   = 3'h0;
        b_out_ack   = 3'h0;
        b_inp_data  = 48'h0;
        sel_dir     = 1'b0;
        sel_ch      = 2'd0;
        sel_ack     = 1'b0;
        sel_data    = 16'h0;
        m_rdata     = 16'h0;

        tick();
        tick();
        chk_idle("reset");
        chk("reset_err_to",  32'(err_timeout), 32'd0);
        chk("reset_err_bad", 32'(err_badch),   32'd0);
        chk("reset_b_busy",  32'(b_busy),      32'd0);
        chk("reset_b_done",  32'(b_done),      32'd0);
        rst_b = 1'b0;
        tick();
        chk_idle("post_reset");

        do_xfer(1'b0, 2'd1, 16'h0, 16'hBEEF, 3, 2, 1'b0);
        tick();
        chk_idle("beef_after");

        do_xfer(1'b1, 2'd3, 16'h1234, 16'($urandom), 2, 2, 1'b0);
        tick();
        chk_idle("out3_after");

        // Stray starts while busy, then a command accepted in the done cycle.
        do_xfer(1'b0, 2'd0, 16'h0, 16'hA5A5, 2, 1, 1'b1);
        do_xfer(1'b1, 2'd2, 16'h5A5A, 16'h0, 0, 1, 1'b1);
        tick();
        chk_idle("chain_after");

        for (int t = 0; t < 40; t++) begin
            do_xfer(1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                    1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                tick();
                chk_idle("rnd_idle");
            end
        end
        tick();
        chk_idle("rnd_after");

        do_xfer(1'b0, 2'd1, 16'h0, 16'h1357, 1, 1, 1'b0);
        tick();

        // Handshake that never sees an ack.
        cmd_start = 1'b1;
        cmd_dir   = 1'b0;
        cmd_ch    = 2'd0;
        sel_dir   = 1'b0;
        sel_ch    = 2'd0;
        sel_ack   = 1'b0;
        sel_data  = 16'h7777;
        tick();
        cmd_start = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && inp_req[0]; i++) begin
            n++;
            noise();
            tick();
        end
`ifdef IO_PORT_CTRL_TIMEOUT_EN
        chk("to_req_cycles", 32'(n),           32'(TO_CYCLES));
        chk("to_done",       32'(done),        32'd1);
        chk("to_err",        32'(err_timeout), 32'd1);
        chk("to_busy",       32'(busy),        32'd0);
        chk("to_rdata",      32'(rdata),       32'(m_rdata));
        tick();
        chk("to_done_clr",   32'(done),        32'd0);
`else
        chk("noto_cycles",   32'(n),           32'd20);
        chk("noto_busy",     32'(busy),        32'd1);
        chk("noto_err",      32'(err_timeout), 32'd0);
        chk("noto_done",     32'(done),        32'd0);
`endif

        // Reset in the middle of an output request on channel 2.
        rst_b = 1'b1;
        tick();
        rst_b   = 1'b0;
        m_rdata = 16'h0;
        do_xfer(1'b0, 2'd3, 16'h0, 16'h2468, 0, 1, 1'b0);
        tick();
        cmd_start = 1'b1;
        cmd_dir   = 1'b1;
        cmd_ch    = 2'd2;
        cmd_wdata = 16'hCAFE;
        sel_dir   = 1'b1;
        sel_ch    = 2'd2;
        sel_ack   = 1'b0;
        noise();
        tick();
        cmd_start = 1'b0;
        chk("rstmid_out_req", 32'(out_req), 32'h4);
        rst_b = 1'b1;
        tick();
        chk("rstmid_out_req0", 32'(out_req),  32'd0);
        chk("rstmid_busy",     32'(busy),     32'd0);
        chk("rstmid_done",     32'(done),     32'd0);
        chk("rstmid_rdata",    32'(rdata),    32'd0);
        chk("rstmid_out_data", 32'(out_data), 32'd0);
        rst_b   = 1'b0;
        m_rdata = 16'h0;

        // Out-of-range channel on the three-channel instance.
        b_cmd_start = 1'b1;
        b_cmd_dir   = 1'b1;
        b_cmd_ch    = 2'd3;
        b_cmd_wdata = 16'h9999;
        tick();
        b_cmd_start = 1'b0;
        chk("bad_inp_req",  32'(b_inp_req),   32'd0);
        chk("bad_out_req",  32'(b_out_req),   32'd0);
        chk("bad_done",     32'(b_done),      32'd1);
        chk("bad_err",      32'(b_err_badch), 32'd1);
        chk("bad_busy",     32'(b_busy),      32'd0);
        chk("bad_out_data", 32'(b_out_data),  32'd0);
        tick();
        chk("bad_done_clr", 32'(b_done),      32'd0);
        chk("bad_sticky",   32'(b_err_badch), 32'd1);
        b_cmd_start = 1'b1;
        b_cmd_ch    = 2'd2;
        b_cmd_wdata = 16'h4321;
        tick();
        b_cmd_start = 1'b0;
        chk("b_ok_out_req",  32'(b_out_req),   32'h4);
        chk("b_ok_err_clr",  32'(b_err_badch), 32'd0);
        chk("b_ok_out_data", 32'(b_out_data),  32'h4321);
        b_out_ack = 3'b100;
        tick();
        chk("b_ok_req_drop", 32'(b_out_req),   32'd0);
        b_out_ack = 3'b000;
        tick();
        chk("b_ok_done",     32'(b_done),      32'd1);
        chk("b_ok_busy",     32'(b_busy),      32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
